// File: rtl/cache_ctrl.sv
// Sequencing controller for a 64-entry direct-mapped, one-word-line cache.
// Zero-stall read hits, read-miss fill, write-through with write-allocate, and saturating hit/miss counters.
module cache_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      cpu_addr,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [31:0]      cpu_wrdata,
    output logic             cpu_stall,
    output logic [31:0]      cpu_rddata,
    output logic             cpu_err,
    output logic [31:0]      c_addr,
    output logic             c_wren,
    output logic [31:0]      c_wrdata,
    input  logic             c_hit,
    input  logic [31:0]      c_q,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_MEM = 3'd1,
        FILL   = 3'd2,
        WR_MEM = 3'd3,
        WR_UPD = 3'd4
    } state_t;

    state_t          state_r;
    logic [31:0]     addr_r;
    logic [31:0]     data_r;
    logic [TW-1:0]   tcnt_r;
    logic            expire_s;

    // An ack arriving in the last allowed cycle still completes the access.
    assign expire_s = (tcnt_r == T_LAST) && !mem_ack;
    assign c_addr   = cpu_addr;

    // Transaction sequencing, address/data latching, timeout and performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            addr_r   <= 32'h0;
            data_r   <= 32'h0;
            tcnt_r   <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_wr) begin
                        addr_r  <= cpu_addr;
                        data_r  <= cpu_wrdata;
                        tcnt_r  <= '0;
                        state_r <= WR_MEM;
                    end else if (cpu_rd) begin
                        if (c_hit) begin
                            if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_W'(1);
                        end else begin
                            if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
                            addr_r  <= cpu_addr;
                            tcnt_r  <= '0;
                            state_r <= RD_MEM;
                        end
                    end
                end
                RD_MEM: begin
                    if (mem_ack) begin
                        data_r  <= mem_rdata;
                        state_r <= FILL;
                    end else if (expire_s) begin
                        state_r <= IDLE;
                    end else begin
                        tcnt_r  <= tcnt_r + TW'(1);
                    end
                end
                WR_MEM: begin
                    if (mem_ack) begin
                        state_r <= WR_UPD;
                    end else if (expire_s) begin
                        state_r <= IDLE;
                    end else begin
                        tcnt_r  <= tcnt_r + TW'(1);
                    end
                end
                FILL:    state_r <= IDLE;
                WR_UPD:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Output decode; the IDLE read path is combinational so hits complete with no stall.
    always_comb begin
        cpu_stall  = 1'b0;
        cpu_rddata = 32'h0;
        cpu_err    = 1'b0;
        c_wren     = 1'b0;
        c_wrdata   = 32'h0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        if (reset) begin
            cpu_stall = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_wr) begin
                        cpu_stall = 1'b1;
                    end else if (cpu_rd) begin
                        cpu_stall  = !c_hit;
                        cpu_rddata = c_hit ? c_q : 32'h0;
                    end else begin
                        cpu_stall = 1'b0;
                    end
                end
                RD_MEM, WR_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = (state_r == WR_MEM);
                    mem_addr  = addr_r;
                    mem_wdata = (state_r == WR_MEM) ? data_r : 32'h0;
                    if (expire_s) begin
                        cpu_err   = 1'b1;
                        cpu_stall = 1'b0;
                    end else begin
                        cpu_stall = 1'b1;
                    end
                end
                FILL: begin
                    c_wren     = 1'b1;
                    c_wrdata   = data_r;
                    cpu_rddata = data_r;
                end
                WR_UPD: begin
                    c_wren   = 1'b1;
                    c_wrdata = data_r;
                end
                default: cpu_stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized scoreboard bench for cache_ctrl: a cache array and memory model around the DUT,
// with expected CPU-visible responses computed from an address/line-level reference model.
module tb_cache_ctrl;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      cpu_addr;
    logic             cpu_rd, cpu_wr;
    logic [31:0]      cpu_wrdata;
    logic             cpu_stall, cpu_err;
    logic [31:0]      cpu_rddata, c_addr, c_wrdata, c_q;
    logic             c_wren, c_hit;
    logic             mem_req, mem_we, mem_ack;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    cache_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wrdata(cpu_wrdata), .cpu_stall(cpu_stall), .cpu_rddata(cpu_rddata), .cpu_err(cpu_err),
        .c_addr(c_addr), .c_wren(c_wren), .c_wrdata(c_wrdata), .c_hit(c_hit), .c_q(c_q),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] data;
        int          stall;
        bit          wren;
        logic [31:0] wrdata;
        int          hits;
        int          misses;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   total = 0;
    int   bad   = 0;

    // Environment: cache array (written on the falling edge) and main memory.
    bit          cval[64];
    logic [23:0] ctag[64];
    logic [31:0] cdat[64];
    logic [31:0] env_mem[logic [31:0]];
    int          cur_delay = 0;
    bit          force_ack = 1'b0;
    bit          mon_off   = 1'b0;

    // Reference model: which tag each index holds, memory contents, expected counters.
    bit          ref_val[64];
    logic [23:0] ref_tag[64];
    logic [31:0] ref_mem[logic [31:0]];
    int          ref_hits   = 0;
    int          ref_misses = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEAF;
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic int sat(input int x);
        return (x >= CNT_MAX) ? x : x + 1;
    endfunction

    assign c_hit = cval[c_addr[7:2]] && (ctag[c_addr[7:2]] == c_addr[31:8]);
    assign c_q   = cdat[c_addr[7:2]];

    always @(negedge clk) begin
        if (c_wren) begin
            cval[c_addr[7:2]] <= 1'b1;
            ctag[c_addr[7:2]] <= c_addr[31:8];
            cdat[c_addr[7:2]] <= c_wrdata;
        end
    end

    // Memory: acks cur_delay cycles after mem_req first rises; never acks if the delay is too long.
    initial begin
        bit busy = 1'b0;
        int wcnt = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = force_ack;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = 0;
                end
                if (wcnt == cur_delay) begin
                    mem_ack = 1'b1;
                    busy    = 1'b0;
                    if (mem_we) env_mem[mem_addr] = mem_wdata;
                    else        mem_rdata = env_rd(mem_addr);
                end else begin
                    wcnt++;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: drains posted checks and compares each completed access against the scoreboard.
    initial begin
        int   stall_cnt = 0;
        bit   pend = 1'b0;
        exp_t pe, e;
        chk_t c;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                check(c.name, c.act, c.exp);
            end
            if (pend) begin
                check("hit_cnt", 32'(hit_cnt), pe.hits);
                check("miss_cnt", 32'(miss_cnt), pe.misses);
                check("mem_req_after_done", 32'(mem_req), 32'd0);
                pend = 1'b0;
            end
            if (!reset && !mon_off && (cpu_rd || cpu_wr)) begin
                check("c_addr", c_addr, cpu_addr);
                if (cpu_stall) begin
                    stall_cnt++;
                    if (stall_cnt > 100) begin
                        check("stall_bound", stall_cnt, 32'd100);
                        stall_cnt = 0;
                    end
                end else begin
                    check("pending_txn", exp_q.size(), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("stall_cycles", stall_cnt, e.stall);
                        check("cpu_err", 32'(cpu_err), 32'(e.err));
                        check("c_wren", 32'(c_wren), 32'(e.wren));
                        if (e.rd)   check("cpu_rddata", cpu_rddata, e.data);
                        if (e.wren) check("c_wrdata", c_wrdata, e.wrdata);
                        pe   = e;
                        pend = 1'b1;
                    end
                    stall_cnt = 0;
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_q.push_back('{name, act, exp});
    endtask

    task automatic finish_txn();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_stall && n < 120);
        @(posedge clk);
        #2;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int d);
        exp_t e;
        int   idx = int'(a[7:2]);
        e.rd = 1'b1; e.err = 1'b0; e.wren = 1'b0; e.wrdata = 32'h0;
        if (ref_val[idx] && ref_tag[idx] == a[31:8]) begin
            e.stall  = 0;
            e.data   = ref_rd(a);
            ref_hits = sat(ref_hits);
        end else begin
            ref_misses = sat(ref_misses);
            if (d < TIMEOUT) begin
                e.stall  = d + 2;
                e.data   = ref_rd(a);
                e.wren   = 1'b1;
                e.wrdata = e.data;
                ref_val[idx] = 1'b1;
                ref_tag[idx] = a[31:8];
            end else begin
                e.err   = 1'b1;
                e.stall = TIMEOUT;
                e.data  = 32'h0;
            end
        end
        e.hits = ref_hits; e.misses = ref_misses;
        exp_q.push_back(e);
        cur_delay = d;
        cpu_addr  = a;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b1;
        finish_txn();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] v, input int d);
        exp_t e;
        int   idx = int'(a[7:2]);
        e.rd = 1'b0; e.data = 32'h0; e.err = 1'b0; e.wren = 1'b0; e.wrdata = 32'h0;
        if (d < TIMEOUT) begin
            e.stall  = d + 2;
            e.wren   = 1'b1;
            e.wrdata = v;
            ref_mem[a]   = v;
            ref_val[idx] = 1'b1;
            ref_tag[idx] = a[31:8];
        end else begin
            e.err   = 1'b1;
            e.stall = TIMEOUT;
        end
        e.hits = ref_hits; e.misses = ref_misses;
        exp_q.push_back(e);
        cur_delay  = d;
        cpu_addr   = a;
        cpu_wrdata = v;
        cpu_rd     = $urandom_range(0, 1) == 1;
        cpu_wr     = 1'b1;
        finish_txn();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wren_seen = 0;
        int req_seen  = 0;
        reset = 1'b1; cpu_addr = 32'h0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wrdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        post("rst_stall", 32'(cpu_stall), 32'd0);
        post("rst_mem_req", 32'(mem_req), 32'd0);
        post("rst_c_wren", 32'(c_wren), 32'd0);
        post("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        post("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        post("idle_err", 32'(cpu_err), 32'd0);
        post("idle_rddata", cpu_rddata, 32'h0);
        @(posedge clk);
        #2;

        // Cold miss, hit, write-allocate, conflict eviction, timeouts.
        do_read(32'h0000_0040, 2);
        do_read(32'h0000_0040, 0);
        do_write(32'h0000_0080, 32'h1234_5678, 0);
        do_read(32'h0000_0080, 0);
        do_read(32'h0000_1040, 1);
        do_read(32'h0000_0040, 1);
        do_read(32'h0000_0300, TIMEOUT);
        do_read(32'h0000_0300, TIMEOUT - 1);
        do_write(32'h0000_0304, 32'hCAFE_F00D, TIMEOUT);
        do_read(32'h0000_0304, 0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int          r, d;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(14, 21) << 2);
            r = $urandom_range(0, 9);
            d = (r < 6) ? r % 4 : (r < 8) ? TIMEOUT - 1 : (r == 8) ? TIMEOUT : 1;
            if ($urandom_range(0, 2) == 0) do_write(a, $urandom, d);
            else                           do_read(a, d);
        end

        // Reset during a read-miss memory wait, followed by a stale ack.
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        mon_off   = 1'b1;
        cur_delay = 1000;
        cpu_addr  = 32'hFFF0_0000;
        cpu_rd    = 1'b1;
        repeat (3) @(negedge clk);
        post("mid_txn_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        reset  = 1'b1;
        cpu_rd = 1'b0;
        @(posedge clk);
        #2;
        reset     = 1'b0;
        force_ack = 1'b1;
        @(posedge clk);
        #2;
        force_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (c_wren)  wren_seen++;
            if (mem_req) req_seen++;
        end
        post("stale_ack_c_wren", wren_seen, 32'd0);
        post("stale_ack_mem_req", req_seen, 32'd0);
        post("post_rst_hit_cnt", 32'(hit_cnt), 32'd0);
        post("post_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        #2;
        mon_off    = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
        do_read(32'hFFF0_0000, 1);

        repeat (3) @(posedge clk);
        post("scoreboard_empty", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
